// File: rtl/note_voice_scheduler.sv
// note_voice_scheduler: shares the left/right speaker voices between NREQ
// prioritised note requesters. Each voice plays a latched divider for a
// requested number of ticks, then rests for an articulation gap.
module note_voice_scheduler #(
   parameter int          NREQ        = 4,
   parameter int          DIV_W       = 22,
   parameter int          DUR_W       = 16,
   parameter int          GAP_TICKS   = 2,
   parameter int unsigned SILENCE_DIV = 0,
   localparam int         OW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  flush,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*DIV_W-1:0] req_div,
   input  logic [NREQ*DUR_W-1:0] req_dur,
   output logic [NREQ-1:0]       ack,
   output logic [NREQ-1:0]       done,
   output logic [NREQ-1:0]       drop,
   output logic [DIV_W-1:0]      left_note_div,
   output logic [DIV_W-1:0]      right_note_div,
   output logic                  left_busy,
   output logic                  right_busy,
   output logic [OW-1:0]         left_owner,
   output logic [OW-1:0]         right_owner
);

   typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} st_t;

   localparam logic [DIV_W-1:0] SIL = DIV_W'(SILENCE_DIV);
   localparam logic [DUR_W-1:0] GAP = DUR_W'(GAP_TICKS);

   // Voice 0 is the left voice, voice 1 the right voice.
   st_t              state_q    [2];
   st_t              state_d    [2];
   logic [DUR_W-1:0] cnt_q      [2];
   logic [DUR_W-1:0] cnt_d      [2];
   logic [DIV_W-1:0] div_q      [2];
   logic [DIV_W-1:0] div_d      [2];
   logic [OW-1:0]    owner_q    [2];
   logic [OW-1:0]    owner_d    [2];
   logic [DIV_W-1:0] note_div_q [2];
   logic [DIV_W-1:0] note_div_d [2];
   logic             busy_q     [2];
   logic             busy_d     [2];
   logic [NREQ-1:0]  ack_q, ack_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic [NREQ-1:0]  drop_q, drop_d;

   logic             cand_vld;
   logic [OW-1:0]    cand;
   logic             tgt;
   logic             tgt_ok;
   logic             preempt;
   logic             grant;
   logic             pre_l;
   logic             pre_r;
   logic             finishing  [2];
   logic [DUR_W-1:0] cand_dur;
   logic [DIV_W-1:0] cand_div;

   // Pick the highest-priority requester and the voice it would land on.
   always_comb begin
      cand_vld = 1'b0;
      cand     = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            cand_vld = 1'b1;
            cand     = OW'(i);
         end
      end
      cand_div = req_div[int'(cand)*DIV_W +: DIV_W];
      cand_dur = req_dur[int'(cand)*DUR_W +: DUR_W];
      for (int v = 0; v < 2; v++) begin
         finishing[v] = tick && (state_q[v] == ST_PLAY) && (cnt_q[v] == DUR_W'(1));
      end
      pre_l   = (state_q[0] == ST_PLAY) && (owner_q[0] > cand);
      pre_r   = (state_q[1] == ST_PLAY) && (owner_q[1] > cand);
      tgt     = 1'b0;
      tgt_ok  = 1'b0;
      preempt = 1'b0;
      if (state_q[0] == ST_IDLE) begin
         tgt    = 1'b0;
         tgt_ok = 1'b1;
      end else if (state_q[1] == ST_IDLE) begin
         tgt    = 1'b1;
         tgt_ok = 1'b1;
      end else if (pre_l || pre_r) begin
         preempt = 1'b1;
         tgt_ok  = 1'b1;
         if (pre_l && pre_r) begin
            tgt = (owner_q[0] > owner_q[1]) ? 1'b0 : 1'b1;
         end else begin
            tgt = pre_r;
         end
      end
      // A requester owning both voices must not see done and drop together;
      // the preemption simply waits one cycle in that corner.
      if (preempt && finishing[~tgt] && (owner_q[~tgt] == owner_q[tgt])) begin
         tgt_ok = 1'b0;
      end
      grant = cand_vld && tgt_ok && !flush;
   end

   // Per-voice next state: flush, then grant, then tick-driven countdown.
   always_comb begin
      ack_d  = '0;
      done_d = '0;
      drop_d = '0;
      if (grant) begin
         ack_d[cand] = 1'b1;
      end
      for (int v = 0; v < 2; v++) begin
         state_d[v] = state_q[v];
         cnt_d[v]   = cnt_q[v];
         div_d[v]   = div_q[v];
         owner_d[v] = owner_q[v];
         if (flush) begin
            if (state_q[v] == ST_PLAY) begin
               drop_d[owner_q[v]] = 1'b1;
            end
            state_d[v] = ST_IDLE;
            cnt_d[v]   = '0;
         end else if (grant && (tgt == v[0])) begin
            if (preempt) begin
               drop_d[owner_q[v]] = 1'b1;
            end
            state_d[v] = ST_PLAY;
            div_d[v]   = cand_div;
            owner_d[v] = cand;
            cnt_d[v]   = (cand_dur == '0) ? DUR_W'(1) : cand_dur;
         end else if (tick) begin
            case (state_q[v])
               ST_PLAY: begin
                  if (cnt_q[v] == DUR_W'(1)) begin
                     done_d[owner_q[v]] = 1'b1;
                     if (GAP_TICKS == 0) begin
                        state_d[v] = ST_IDLE;
                        cnt_d[v]   = '0;
                     end else begin
                        state_d[v] = ST_GAP;
                        cnt_d[v]   = GAP;
                     end
                  end else begin
                     cnt_d[v] = cnt_q[v] - DUR_W'(1);
                  end
               end
               ST_GAP: begin
                  if (cnt_q[v] == DUR_W'(1)) begin
                     state_d[v] = ST_IDLE;
                     cnt_d[v]   = '0;
                  end else begin
                     cnt_d[v] = cnt_q[v] - DUR_W'(1);
                  end
               end
               default: begin
                  cnt_d[v] = cnt_q[v];
               end
            endcase
         end
         busy_d[v]     = (state_d[v] != ST_IDLE);
         note_div_d[v] = (state_d[v] == ST_PLAY) ? div_d[v] : SIL;
      end
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q  <= '0;
         done_q <= '0;
         drop_q <= '0;
         for (int v = 0; v < 2; v++) begin
            state_q[v]    <= ST_IDLE;
            cnt_q[v]      <= '0;
            div_q[v]      <= SIL;
            owner_q[v]    <= '0;
            note_div_q[v] <= SIL;
            busy_q[v]     <= 1'b0;
         end
      end else begin
         ack_q  <= ack_d;
         done_q <= done_d;
         drop_q <= drop_d;
         for (int v = 0; v < 2; v++) begin
            state_q[v]    <= state_d[v];
            cnt_q[v]      <= cnt_d[v];
            div_q[v]      <= div_d[v];
            owner_q[v]    <= owner_d[v];
            note_div_q[v] <= note_div_d[v];
            busy_q[v]     <= busy_d[v];
         end
      end
   end

   assign ack            = ack_q;
   assign done           = done_q;
   assign drop           = drop_q;
   assign left_note_div  = note_div_q[0];
   assign right_note_div = note_div_q[1];
   assign left_busy      = busy_q[0];
   assign right_busy     = busy_q[1];
   assign left_owner     = owner_q[0];
   assign right_owner    = owner_q[1];

endmodule

// File: tb/tb_note_voice_scheduler.sv
// Directed bench for note_voice_scheduler: expectations are queued as each
// step is driven and checked one edge later. A second instance built with
// GAP_TICKS=0 shares the stimulus.
module tb_note_voice_scheduler;

   localparam int NREQ  = 4;
   localparam int DIV_W = 22;
   localparam int DUR_W = 16;
   localparam int OW    = 2;

   localparam int S_ACK = 0, S_DONE = 1, S_DROP = 2, S_LDIV = 3, S_RDIV = 4;
   localparam int S_LBUSY = 5, S_RBUSY = 6, S_LOWN = 7, S_ROWN = 8;
   localparam int S_G0DONE = 9, S_G0LBUSY = 10;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  tick = 1'b0;
   logic                  flush = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*DIV_W-1:0] req_div = '0;
   logic [NREQ*DUR_W-1:0] req_dur = '0;

   logic [NREQ-1:0]  ack, done, drop;
   logic [DIV_W-1:0] ldiv, rdiv;
   logic             lbusy, rbusy;
   logic [OW-1:0]    lown, rown;

   logic [NREQ-1:0]  g0_ack, g0_done, g0_drop;
   logic [DIV_W-1:0] g0_ldiv, g0_rdiv;
   logic             g0_lbusy, g0_rbusy;
   logic [OW-1:0]    g0_lown, g0_rown;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] val;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   note_voice_scheduler #(.NREQ(NREQ), .DIV_W(DIV_W), .DUR_W(DUR_W), .GAP_TICKS(2)) u_dut (
      .clk(clk), .rst(rst), .tick(tick), .flush(flush), .req(req),
      .req_div(req_div), .req_dur(req_dur), .ack(ack), .done(done), .drop(drop),
      .left_note_div(ldiv), .right_note_div(rdiv), .left_busy(lbusy),
      .right_busy(rbusy), .left_owner(lown), .right_owner(rown)
   );

   note_voice_scheduler #(.NREQ(NREQ), .DIV_W(DIV_W), .DUR_W(DUR_W), .GAP_TICKS(0)) u_dut_g0 (
      .clk(clk), .rst(rst), .tick(tick), .flush(flush), .req(req),
      .req_div(req_div), .req_dur(req_dur), .ack(g0_ack), .done(g0_done), .drop(g0_drop),
      .left_note_div(g0_ldiv), .right_note_div(g0_rdiv), .left_busy(g0_lbusy),
      .right_busy(g0_rbusy), .left_owner(g0_lown), .right_owner(g0_rown)
   );

   function automatic logic [31:0] obs(input int sel);
      case (sel)
         S_ACK:     return 32'(ack);
         S_DONE:    return 32'(done);
         S_DROP:    return 32'(drop);
         S_LDIV:    return 32'(ldiv);
         S_RDIV:    return 32'(rdiv);
         S_LBUSY:   return 32'(lbusy);
         S_RBUSY:   return 32'(rbusy);
         S_LOWN:    return 32'(lown);
         S_ROWN:    return 32'(rown);
         S_G0DONE:  return 32'(g0_done);
         S_G0LBUSY: return 32'(g0_lbusy);
         default:   return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic set_slot(input int i, input int unsigned dv, input int unsigned du);
      req_div[i*DIV_W +: DIV_W] = DIV_W'(dv);
      req_dur[i*DUR_W +: DUR_W] = DUR_W'(du);
   endtask

   // One clock with the given tick level, then check everything queued.
   task automatic step(input logic tk);
      exp_t        e;
      logic [31:0] o;
      tick = tk;
      @(posedge clk);
      #1;
      tick = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs(e.sel);
         n_checks++;
         assert (o === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      step(1'b0);
      rst = 1'b0;
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      step(1'b0);
      push("rst_ack", S_ACK, 0);      push("rst_done", S_DONE, 0);
      push("rst_drop", S_DROP, 0);    push("rst_ldiv", S_LDIV, 0);
      push("rst_rdiv", S_RDIV, 0);    push("rst_lbusy", S_LBUSY, 0);
      push("rst_rbusy", S_RBUSY, 0);  push("rst_lown", S_LOWN, 0);
      push("rst_rown", S_ROWN, 0);
      step(1'b0);
      rst = 1'b0;

      // Single note, ticks every 10 cycles, with articulation gap
      set_slot(2, 191113, 3);
      req = 4'b0100;
      push("t1_ack", S_ACK, 4'b0100);  push("t1_ldiv", S_LDIV, 191113);
      push("t1_lbusy", S_LBUSY, 1);    push("t1_lown", S_LOWN, 2);
      step(1'b0);
      req = '0;
      push("t1_ack_off", S_ACK, 0);
      step(1'b0);
      idle(8);
      push("t1_tk1_div", S_LDIV, 191113); push("t1_tk1_done", S_DONE, 0);
      step(1'b1);
      idle(9);
      push("t1_tk2_div", S_LDIV, 191113); push("t1_tk2_done", S_DONE, 0);
      step(1'b1);
      idle(9);
      push("t1_tk3_done", S_DONE, 4'b0100); push("t1_tk3_div", S_LDIV, 0);
      push("t1_tk3_busy", S_LBUSY, 1);
      push("g0_tk3_done", S_G0DONE, 4'b0100); push("g0_tk3_busy", S_G0LBUSY, 0);
      step(1'b1);
      push("t1_done_off", S_DONE, 0);
      step(1'b0);
      idle(8);
      push("t1_gap1_busy", S_LBUSY, 1);
      step(1'b1);
      idle(9);
      push("t1_gap2_busy", S_LBUSY, 0); push("t1_gap2_div", S_LDIV, 0);
      step(1'b1);

      // Two requests in one cycle: one grant per cycle, lower index first
      set_slot(1, 1000, 50);
      set_slot(3, 3000, 50);
      req = 4'b1010;
      push("t2_ack1", S_ACK, 4'b0010); push("t2_lown", S_LOWN, 1);
      push("t2_ldiv", S_LDIV, 1000);   push("t2_lbusy", S_LBUSY, 1);
      step(1'b0);
      req = 4'b1000;
      push("t2_ack3", S_ACK, 4'b1000); push("t2_rown", S_ROWN, 3);
      push("t2_rdiv", S_RDIV, 3000);   push("t2_rbusy", S_RBUSY, 1);
      push("t2_lown_keep", S_LOWN, 1);
      step(1'b0);
      req = '0;
      push("t2_ack_off", S_ACK, 0);
      step(1'b0);

      // Preemption of the larger-owner voice
      do_reset();
      set_slot(2, 2222, 20);
      req = 4'b0100;
      push("t3_ack2", S_ACK, 4'b0100); push("t3_lown", S_LOWN, 2);
      step(1'b0);
      set_slot(3, 3333, 20);
      req = 4'b1000;
      push("t3_ack3", S_ACK, 4'b1000); push("t3_rown", S_ROWN, 3);
      step(1'b0);
      set_slot(0, 1111, 5);
      req = 4'b0001;
      push("t3_ack0", S_ACK, 4'b0001);  push("t3_drop3", S_DROP, 4'b1000);
      push("t3_rdiv", S_RDIV, 1111);    push("t3_rown0", S_ROWN, 0);
      push("t3_lown2", S_LOWN, 2);      push("t3_ldiv", S_LDIV, 2222);
      push("t3_rbusy", S_RBUSY, 1);
      step(1'b0);
      req = '0;
      push("t3_drop_off", S_DROP, 0); push("t3_ack_off", S_ACK, 0);
      step(1'b0);

      // No preemption of higher-priority owners; wait through the gap
      do_reset();
      set_slot(0, 10, 1);
      req = 4'b0001;
      push("t4_ack0", S_ACK, 4'b0001); push("t4_lown", S_LOWN, 0);
      step(1'b0);
      set_slot(1, 20, 3);
      req = 4'b0010;
      push("t4_ack1", S_ACK, 4'b0010); push("t4_rown", S_ROWN, 1);
      step(1'b0);
      set_slot(2, 30, 5);
      req = 4'b0100;
      push("t4_wait_a", S_ACK, 0);
      step(1'b0);
      push("t4_wait_b", S_ACK, 0);
      step(1'b0);
      push("t4_tk1_ack", S_ACK, 0);     push("t4_tk1_done", S_DONE, 4'b0001);
      push("t4_tk1_lbusy", S_LBUSY, 1); push("t4_tk1_ldiv", S_LDIV, 0);
      step(1'b1);
      push("t4_tk2_ack", S_ACK, 0);     push("t4_tk2_lbusy", S_LBUSY, 1);
      push("t4_tk2_done", S_DONE, 0);
      step(1'b1);
      push("t4_tk3_ack", S_ACK, 0);     push("t4_tk3_lbusy", S_LBUSY, 0);
      push("t4_tk3_done", S_DONE, 4'b0010); push("t4_tk3_rbusy", S_RBUSY, 1);
      step(1'b1);
      push("t4_ack2", S_ACK, 4'b0100);  push("t4_lown2", S_LOWN, 2);
      push("t4_ldiv", S_LDIV, 30);      push("t4_lbusy", S_LBUSY, 1);
      step(1'b0);
      req = '0;
      push("t4_ack_off", S_ACK, 0);
      step(1'b0);

      // Zero duration plays exactly one tick
      do_reset();
      set_slot(0, 55, 0);
      req = 4'b0001;
      push("t5_ack", S_ACK, 4'b0001); push("t5_ldiv", S_LDIV, 55);
      push("t5_lbusy", S_LBUSY, 1);
      step(1'b0);
      req = '0;
      push("t5_ack_off", S_ACK, 0);
      step(1'b0);
      push("t5_done", S_DONE, 4'b0001);   push("t5_ldiv_sil", S_LDIV, 0);
      push("t5_lbusy_gap", S_LBUSY, 1);
      push("g0_t5_done", S_G0DONE, 4'b0001); push("g0_t5_lbusy", S_G0LBUSY, 0);
      step(1'b1);

      // Flush with left playing (owner 1) and right in its gap
      do_reset();
      set_slot(1, 100, 10);
      req = 4'b0010;
      push("t6_ack1", S_ACK, 4'b0010); push("t6_lown", S_LOWN, 1);
      step(1'b0);
      set_slot(0, 200, 1);
      req = 4'b0001;
      push("t6_ack0", S_ACK, 4'b0001); push("t6_rown", S_ROWN, 0);
      push("t6_rdiv", S_RDIV, 200);
      step(1'b0);
      req = '0;
      push("t6_done0", S_DONE, 4'b0001); push("t6_rbusy_gap", S_RBUSY, 1);
      push("t6_rdiv_sil", S_RDIV, 0);    push("t6_ldiv", S_LDIV, 100);
      step(1'b1);
      flush = 1'b1;
      set_slot(2, 300, 4);
      req = 4'b0100;
      push("t6_fl_drop", S_DROP, 4'b0010); push("t6_fl_ack", S_ACK, 0);
      push("t6_fl_done", S_DONE, 0);       push("t6_fl_ldiv", S_LDIV, 0);
      push("t6_fl_rdiv", S_RDIV, 0);       push("t6_fl_lbusy", S_LBUSY, 0);
      push("t6_fl_rbusy", S_RBUSY, 0);
      step(1'b1);
      flush = 1'b0;
      push("t6_ack2", S_ACK, 4'b0100); push("t6_lown2", S_LOWN, 2);
      push("t6_ldiv2", S_LDIV, 300);   push("t6_drop_off", S_DROP, 0);
      step(1'b0);
      req = '0;

      // Reset in the middle of a note
      rst = 1'b1;
      push("t7_ack", S_ACK, 0);     push("t7_done", S_DONE, 0);
      push("t7_drop", S_DROP, 0);   push("t7_ldiv", S_LDIV, 0);
      push("t7_lbusy", S_LBUSY, 0); push("t7_lown", S_LOWN, 0);
      step(1'b1);
      rst = 1'b0;
      step(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/note_voice_scheduler.md
Name: note_voice_scheduler

Overview:
- Shares the two stereo voices of the speaker path (left_note_div / right_note_div into the buzzer/I2S chain) between NREQ note requesters, such as key presses, background melody and sound effects.
- Allocates a free voice, or preempts a lower-priority voice, and holds the note for a requested number of ticks.
- After each note it inserts a silent articulation gap, then frees the voice.
- Sits between the game logic and the speaker block, on the system clock.

Parameters:
NREQ, 4, number of requesters; index 0 is the highest priority.
DIV_W, 22, note divider width.
DUR_W, 16, duration width, in ticks.
GAP_TICKS, 2, silent ticks after a naturally finished note; 0 means no gap.
SILENCE_DIV, 0, divider value driven while a voice is silent.

Ports:
clk  in  1  system clock.
rst  in  1  reset; one clock, synchronous, active-high.
tick  in  1  single-cycle timebase strobe, e.g. 1 kHz.
flush  in  1  forces both voices silent and idle.
req  in  NREQ  level request per requester, held until ack.
req_div  in  NREQ*DIV_W  packed note divider; slot i = bits [i*DIV_W +: DIV_W].
req_dur  in  NREQ*DUR_W  packed duration in ticks; 0 is treated as 1.
ack  out  NREQ  1-cycle grant pulse.
done  out  NREQ  1-cycle pulse when requester's note finishes naturally.
drop  out  NREQ  1-cycle pulse when requester's note is preempted or flushed.
left_note_div  out  DIV_W  divider for left voice.
right_note_div  out  DIV_W  divider for right voice.
left_busy, right_busy  out  1  voice is in PLAY or GAP.
left_owner, right_owner  out  clog2(NREQ)  owning requester; valid while busy.

Behaviour:
- Reset, synchronous: both voices IDLE; note_div = SILENCE_DIV; busy = 0; owner = 0; counters = 0; ack/done/drop = 0.
- Per-voice FSM:
  - IDLE: output SILENCE_DIV.
  - PLAY: output the latched div. Counter decrements by 1 on each tick. On a tick with cnt==1: done[owner] pulses; go to GAP with cnt = GAP_TICKS, or to IDLE if GAP_TICKS==0.
  - GAP: output SILENCE_DIV. Counter decrements by 1 on each tick. On a tick with cnt==1: go to IDLE.
- Arbitration: at most one grant per cycle.
  - Candidate c = lowest index with req[c]==1.
  - If left IDLE: grant to left.
  - Else if right IDLE: grant to right.
  - Else preempt a PLAY voice whose owner index > c. If both qualify, preempt the one with the larger owner index; on a tie, preempt right. drop[old owner] pulses.
  - GAP voices are never preempted.
  - Otherwise no grant; c waits and the lower-index-first rule is re-evaluated every cycle.
- On grant:
  - ack[c] = 1, div latched, owner = c, state = PLAY, cnt = max(req_dur[c], 1).
  - All outputs are registered: req sampled in cycle N gives ack and the new note_div visible in cycle N+1.
  - Requester must drop req in the cycle after ack; a req still high then is a new request.
- Grant and tick in the same cycle on the same voice: the count is loaded and the tick is ignored for that voice.
- A voice finishing (PLAY/GAP to IDLE) on a tick is not grantable until the following cycle; grants see registered state only.
- Same requester may own both voices with two separate requests.
- flush:
  - Next cycle both voices are IDLE/silent.
  - drop pulses for owners of PLAY voices only.
  - No ack that cycle; flush overrides req and tick.
- rst asserted mid-note: outputs return to reset values next cycle; no done/drop pulses.
- done and drop never pulse in the same cycle for the same requester.

Test Plan:
- After reset: req[2]=1, div=191113, dur=3, tick every 10 cycles → ack[2] in next cycle; left_note_div=191113 for 3 ticks; done[2] at the 3rd tick; then SILENCE_DIV for 2 ticks; then left_busy=0.
- req[1] and req[3] asserted in the same cycle → cycle 1: ack[1], left owner 1. Cycle 2: ack[3], right owner 3.
- Both voices playing owners 2 and 3; req[0] → right preempted: drop[3], ack[0], right_note_div = req_div[0], right_owner=0. Left unchanged.
- Both voices playing owners 0 and 1; req[2] → no ack until the first voice returns to IDLE after its gap, then ack[2] on the next cycle.
- req_dur=0 → note lasts exactly 1 tick; GAP_TICKS=0 build → busy drops on the same tick as done.
- flush during PLAY on left (owner 1) and GAP on right → drop[1] only; both outputs SILENCE_DIV next cycle; a req high that cycle is acked one cycle later.
